// File: rtl/amp_pwr_seq.sv
// rtl/amp_pwr_seq.sv - class-D amplifier power/fault sequencer with click-free mute
//
// Owns the amplifier shutdown line. It holds the amplifier off for a fixed time
// after reset and after each fault. Faults are filtered, and timed retries run
// until a lockout is reached. The mute request only releases on an audio-sample
// strobe, so the speaker path never starts mid-sample.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   Flt_n        asynchronous amplifier fault, active low
//   vld          one-cycle audio-sample strobe
//   clr_lockout  one-cycle pulse that leaves lockout
//   sht_dwn      amplifier shutdown, active high (registered)
//   mute         zero-audio request (registered)
//   lockout      high while locked out (registered)
//   retry_cnt    faults taken since the last clear
module amp_pwr_seq #(
  parameter int HOLD_CYC   = 250000,
  parameter int UNMUTE_DLY = 50000,
  parameter int FLT_FILT   = 4,
  parameter int MAX_RETRY  = 3,
  parameter int STABLE_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Flt_n,
  input  logic       vld,
  input  logic       clr_lockout,
  output logic       sht_dwn,
  output logic       mute,
  output logic       lockout,
  output logic [3:0] retry_cnt
);

  localparam int TMAX_HU = (HOLD_CYC > UNMUTE_DLY) ? HOLD_CYC : UNMUTE_DLY;
  localparam int TMAX    = (TMAX_HU > STABLE_CYC) ? TMAX_HU : STABLE_CYC;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int FW      = $clog2(FLT_FILT + 1);

  // Timer compares use "last count minus one", so the transition edge lands
  // exactly N edges after the timer was cleared.
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] UNMUTE_LAST = TW'(UNMUTE_DLY - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] STABLE_SAT  = TW'(STABLE_CYC);
  localparam logic [FW-1:0] FILT_MAX    = FW'(FLT_FILT);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_UNMUTE_WAIT,
    ST_RUN,
    ST_FAULT,
    ST_LOCKOUT
  } state_t;

  state_t        state;
  logic          flt_s1;
  logic          flt_s2;
  logic [FW-1:0] fcnt;
  logic          fault_q;
  logic [TW-1:0] timer;

  // Synchronizer and consecutive-low filter. Any high sample restarts the count,
  // so short glitches never qualify.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_s1  <= 1'b1;
      flt_s2  <= 1'b1;
      fcnt    <= '0;
      fault_q <= 1'b0;
    end else begin
      flt_s1 <= Flt_n;
      flt_s2 <= flt_s1;
      if (flt_s2) begin
        fcnt <= '0;
      end else if (fcnt != FILT_MAX) begin
        fcnt <= fcnt + FW'(1);
      end
      fault_q <= (fcnt == FILT_MAX);
    end
  end

  // Sequencer. The outputs are assigned on the same edge as the state change,
  // so sht_dwn, mute and lockout track the new state with no extra cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_STARTUP;
      timer     <= '0;
      retry_cnt <= 4'd0;
      sht_dwn   <= 1'b1;
      mute      <= 1'b1;
      lockout   <= 1'b0;
    end else begin
      case (state)
        ST_STARTUP, ST_FAULT: begin
          // An active fault keeps the hold from starting its count.
          if (fault_q) begin
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state   <= ST_UNMUTE_WAIT;
            timer   <= '0;
            sht_dwn <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_UNMUTE_WAIT, ST_RUN: begin
          // A fault takes priority over any timer expiry on the same edge.
          if (fault_q) begin
            sht_dwn <= 1'b1;
            mute    <= 1'b1;
            timer   <= '0;
            if (retry_cnt < RETRY_MAX) begin
              state     <= ST_FAULT;
              retry_cnt <= retry_cnt + 4'd1;
            end else begin
              state   <= ST_LOCKOUT;
              lockout <= 1'b1;
            end
          end else if (state == ST_UNMUTE_WAIT) begin
            if (timer == UNMUTE_LAST) begin
              state <= ST_RUN;
              timer <= '0;
              if (vld) begin
                mute <= 1'b0;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            // Mute releases only on a sample strobe.
            if (vld) begin
              mute <= 1'b0;
            end
            // The timer saturates after the stable period; retry_cnt clears once.
            if (timer != STABLE_SAT) begin
              timer <= timer + TW'(1);
              if (timer == STABLE_LAST) begin
                retry_cnt <= 4'd0;
              end
            end
          end
        end

        ST_LOCKOUT: begin
          if (clr_lockout) begin
            state     <= ST_STARTUP;
            timer     <= '0;
            retry_cnt <= 4'd0;
            lockout   <= 1'b0;
          end
        end

        default: begin
          state   <= ST_STARTUP;
          timer   <= '0;
          sht_dwn <= 1'b1;
          mute    <= 1'b1;
          lockout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amp_pwr_seq.sv
// tb/tb_amp_pwr_seq.sv - self-checking bench for amp_pwr_seq
module tb_amp_pwr_seq;

  localparam int HOLD   = 100;
  localparam int UNMUTE = 20;
  localparam int FILT   = 4;
  localparam int MAXR   = 3;
  localparam int STABLE = 1000;

  localparam int M_HOLD = 0;  // amplifier held off (startup or fault recovery)
  localparam int M_WAIT = 1;  // amplifier on, still muted
  localparam int M_RUN  = 2;  // playing
  localparam int M_LOCK = 3;  // locked out

  logic       clk;
  logic       rst_n;
  logic       flt_n;
  logic       vld;
  logic       clr_lockout;
  logic       sht_dwn;
  logic       mute;
  logic       lockout;
  logic [3:0] retry_cnt;

  amp_pwr_seq #(
    .HOLD_CYC  (HOLD),
    .UNMUTE_DLY(UNMUTE),
    .FLT_FILT  (FILT),
    .MAX_RETRY (MAXR),
    .STABLE_CYC(STABLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Flt_n      (flt_n),
    .vld        (vld),
    .clr_lockout(clr_lockout),
    .sht_dwn    (sht_dwn),
    .mute       (mute),
    .lockout    (lockout),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int   ncomp;
  int   nfail;
  int   ecnt;      // number of the most recent rising edge
  int   md;
  int   mark;      // edge from which the current delay is measured
  int   m_retry;
  logic m_mute;
  logic hist[$];   // Flt_n samples, most recent first

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncomp++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, ecnt, got, exp);
    end
  endtask

  // Reference behaviour from timestamps: a fault is seen by the sequencer when
  // the FILT samples taken 4..FILT+3 edges ago were all low.
  task automatic model_edge(input logic f, input logic v, input logic c, input logic rn);
    logic fq;
    hist.push_front(f);
    void'(hist.pop_back());
    if (!rn) begin
      foreach (hist[k]) hist[k] = 1'b1;
      md = M_HOLD;
      mark = ecnt;
      m_retry = 0;
      m_mute = 1'b1;
      return;
    end
    fq = 1'b1;
    for (int k = 4; k < FILT + 4; k++) begin
      if (hist[k]) fq = 1'b0;
    end
    case (md)
      M_HOLD: begin
        if (fq) mark = ecnt;
        else if (ecnt - mark == HOLD) begin
          md = M_WAIT;
          mark = ecnt;
        end
      end
      M_WAIT, M_RUN: begin
        if (fq) begin
          if (m_retry < MAXR) begin
            m_retry++;
            md = M_HOLD;
            mark = ecnt;
          end else begin
            md = M_LOCK;
          end
        end else if (md == M_WAIT && ecnt - mark == UNMUTE) begin
          md = M_RUN;
          mark = ecnt;
        end else if (md == M_RUN && ecnt - mark == STABLE) begin
          m_retry = 0;
        end
      end
      default: begin
        if (c) begin
          md = M_HOLD;
          mark = ecnt;
          m_retry = 0;
        end
      end
    endcase
    if (md != M_RUN) m_mute = 1'b1;
    else if (v) m_mute = 1'b0;
  endtask

  task automatic step(input logic f, input logic c);
    flt_n = f;
    clr_lockout = c;
    vld = ((ecnt + 1) % 16 == 15);
    @(posedge clk);
    ecnt++;
    model_edge(f, vld, c, rst_n);
    @(negedge clk);
    chk("sht_dwn", 32'(sht_dwn), 32'(md == M_HOLD || md == M_LOCK));
    chk("mute", 32'(mute), 32'(m_mute));
    chk("lockout", 32'(lockout), 32'(md == M_LOCK));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  task automatic pulse(input int len);
    for (int i = 0; i < len; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
  endtask

  // which: 0 = sht_dwn, 1 = mute. Returns the edge after which val was seen.
  task automatic run_until(input int which, input logic val, input int limit, output int e);
    int n;
    n = 0;
    while (((which == 0) ? sht_dwn : mute) !== val && n < limit) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("wait_bound", 32'(((which == 0) ? sht_dwn : mute) === val), 32'd1);
    e = ecnt;
  endtask

  function automatic int next_vld(input int e0);
    int e;
    e = e0;
    while (e % 16 != 15) e++;
    return e;
  endfunction

  initial begin
    int r;
    int p;
    int e;
    int e2;
    int kind;
    int len;
    clk = 1'b0;
    rst_n = 1'b0;
    flt_n = 1'b1;
    vld = 1'b0;
    clr_lockout = 1'b0;
    ncomp = 0;
    nfail = 0;
    ecnt = -1;
    md = M_HOLD;
    mark = 0;
    m_retry = 0;
    m_mute = 1'b1;
    for (int i = 0; i < 16; i++) hist.push_back(1'b1);

    // Reset and power-up hold
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    r = ecnt;
    chk("rst_sht_dwn", 32'(sht_dwn), 32'd1);
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    rst_n = 1'b1;
    run_until(0, 1'b0, 300, e);
    chk("startup_hold_len", 32'(e - r), 32'(HOLD));
    run_until(1, 1'b0, 300, e);
    chk("startup_unmute_edge", 32'(e), 32'(next_vld(r + HOLD + UNMUTE)));
    repeat (10) step(1'b1, 1'b0);

    // Glitch filter: 3-cycle pulse ignored, 4-cycle pulse qualifies
    pulse(3);
    repeat (10) step(1'b1, 1'b0);
    chk("glitch3_sht", 32'(sht_dwn), 32'd0);
    chk("glitch3_mute", 32'(mute), 32'd0);
    chk("glitch3_retry", 32'(retry_cnt), 32'd0);
    p = ecnt + 1;
    repeat (4) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    chk("flt_edge6_sht", 32'(sht_dwn), 32'd0);
    step(1'b1, 1'b0);
    chk("flt_edge7_sht", 32'(sht_dwn), 32'd1);
    chk("flt_edge7_mute", 32'(mute), 32'd1);
    chk("flt_edge7_retry", 32'(retry_cnt), 32'd1);
    run_until(0, 1'b0, 300, e);
    chk("fault_hold_len", 32'(e - p), 32'(FILT + 3 + HOLD));
    run_until(1, 1'b0, 300, e2);
    chk("fault_unmute_edge", 32'(e2), 32'(next_vld(e + UNMUTE)));

    // Retry decay after a long stable run
    repeat (600) step(1'b1, 1'b0);
    chk("decay_early_retry", 32'(retry_cnt), 32'd1);
    repeat (600) step(1'b1, 1'b0);
    chk("decay_retry", 32'(retry_cnt), 32'd0);

    // Four quick faults reach lockout
    for (int k = 1; k <= MAXR; k++) begin
      pulse(4);
      chk("lock_seq_retry", 32'(retry_cnt), 32'(k));
      chk("lock_seq_lockout", 32'(lockout), 32'd0);
      run_until(0, 1'b0, 200, e);
    end
    pulse(4);
    chk("lockout_set", 32'(lockout), 32'd1);
    chk("lockout_retry", 32'(retry_cnt), 32'(MAXR));
    repeat (5) begin
      pulse(6);
      repeat (50) step(1'b1, 1'b0);
    end
    chk("lockout_hold_sht", 32'(sht_dwn), 32'd1);
    chk("lockout_hold_mute", 32'(mute), 32'd1);
    chk("lockout_hold_lock", 32'(lockout), 32'd1);
    step(1'b1, 1'b1);
    r = ecnt;
    chk("clr_lockout", 32'(lockout), 32'd0);
    chk("clr_retry", 32'(retry_cnt), 32'd0);
    run_until(0, 1'b0, 300, e);
    chk("clr_hold_len", 32'(e - r), 32'(HOLD));

    // Fault held low through the recovery hold
    run_until(1, 1'b0, 200, e);
    p = ecnt + 1;
    repeat (500) step(1'b0, 1'b0);
    chk("held_retry", 32'(retry_cnt), 32'd1);
    run_until(0, 1'b0, 300, e);
    chk("held_hold_len", 32'(e - p), 32'(500 + 3 + HOLD));
    chk("held_retry_after", 32'(retry_cnt), 32'd1);

    // Reset in the middle of fault recovery
    pulse(4);
    chk("midrst_pre_retry", 32'(retry_cnt), 32'd2);
    repeat (5) step(1'b1, 1'b0);
    chk("midrst_pre_sht", 32'(sht_dwn), 32'd1);
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    r = ecnt;
    chk("midrst_retry", 32'(retry_cnt), 32'd0);
    chk("midrst_sht", 32'(sht_dwn), 32'd1);
    chk("midrst_mute", 32'(mute), 32'd1);
    chk("midrst_lockout", 32'(lockout), 32'd0);
    rst_n = 1'b1;
    run_until(0, 1'b0, 300, e);
    chk("midrst_hold_len", 32'(e - r), 32'(HOLD));

    // Randomized traffic against the reference behaviour
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rst_n = 1'b0;
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b1;
      end else if (kind == 1) begin
        step(1'b1, 1'b1);
      end else if (kind == 2) begin
        len = $urandom_range(20, 200);
        for (int i = 0; i < len; i++) step(1'b0, 1'b0);
      end else if (kind == 3) begin
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b0);
      end else begin
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) step(1'b0, 1'b0);
      end
      len = $urandom_range(5, 250);
      for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/amp_pwr_seq.md
# amp_pwr_seq

Amplifier power and fault sequencer for the equalizer top level. It replaces the inline `sht_dwn`/`Flt_n` logic. It owns the class-D amplifier shutdown line, the 5 ms power-up hold, fault filtering, timed retry and lockout. It also produces a click-free `mute` that the top level uses to force the `spkr_drv` channel inputs to zero. It sits beside `spkr_drv` and samples the same `vld` strobe from `I2S_Slave`.

## Interface
- `HOLD_CYC`, 250000, cycles `sht_dwn` is held high at power-up and after each fault (5 ms at 50 MHz).
- `UNMUTE_DLY`, 50000, cycles after `sht_dwn` falls before unmute is requested (1 ms).
- `FLT_FILT`, 4, consecutive synchronized-low samples of `Flt_n` required to qualify a fault (≥1).
- `MAX_RETRY`, 3, fault recoveries allowed before lockout (1..15).
- `STABLE_CYC`, 50000000, continuous `RUN` cycles after which `retry_cnt` clears (1 s).
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  synchronous, active-low reset (output of `rst_synch`).
- `Flt_n`  in  1  asynchronous amplifier fault, active low.
- `vld`  in  1  one-cycle audio-sample strobe from `I2S_Slave`.
- `clr_lockout`  in  1  one-cycle pulse; leaves `LOCKOUT`.
- `sht_dwn`  out  1  amplifier shutdown, active high, registered.
- `mute`  out  1  zero-audio request to the top level, registered.
- `lockout`  out  1  high while in `LOCKOUT`, registered.
- `retry_cnt`  out  4  faults taken since the last clear.

## Operation
- `Flt_n` passes through a 2-flop synchronizer to give `s2`.
- Filter counter `fcnt` increments on every edge where `s2`=0 and saturates at `FLT_FILT`. It clears to 0 on any edge where `s2`=1.
- Registered `fault_q` = (`fcnt` reaches `FLT_FILT`).
- One shared down/up timer; width must cover the largest parameter.
- FSM states: `STARTUP`, `UNMUTE_WAIT`, `RUN`, `FAULT`, `LOCKOUT`.
- `sht_dwn` = 1 in `STARTUP`, `FAULT` and `LOCKOUT`; 0 otherwise.
- `STARTUP`:
  - Timer counts up.
  - If `fault_q` is high, the timer is held at 0 and `retry_cnt` is not incremented.
  - Timer reaching `HOLD_CYC` with `fault_q` low → `UNMUTE_WAIT`, timer cleared.
- `UNMUTE_WAIT`:
  - `fault_q` → fault entry.
  - Timer reaching `UNMUTE_DLY` → `RUN`, timer cleared.
- `RUN`:
  - `fault_q` → fault entry.
  - Timer counts `STABLE_CYC` cycles, then `retry_cnt` ← 0. The timer saturates and `RUN` continues.
- Fault entry:
  - If `retry_cnt` < `MAX_RETRY`: `retry_cnt`+1, → `FAULT`, timer cleared.
  - Otherwise → `LOCKOUT`; `retry_cnt` is unchanged.
- `FAULT`:
  - Timer is held at 0 while `fault_q` is high; otherwise it counts.
  - Timer reaching `HOLD_CYC` → `UNMUTE_WAIT`.
- `LOCKOUT`:
  - `clr_lockout` → `STARTUP`, `retry_cnt` ← 0, timer cleared.
  - `Flt_n` activity is ignored.
- `clr_lockout` in any other state has no effect.
- Mute request = (state ≠ `RUN`).
  - `mute` sets on the edge after the request rises, independent of `vld`.
  - `mute` clears only on an edge where both the request is low and `vld`=1.
- Simultaneous `fault_q` and timer expiry: the fault wins.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-operation, gives:
  - state `STARTUP`, `sht_dwn`=1, `mute`=1, `lockout`=0, `retry_cnt`=0;
  - timer, `fcnt`, `fault_q` and both synchronizer flops cleared; synchronizer flops reset to 1 (no fault).
- Power-up: `sht_dwn` stays high for exactly `HOLD_CYC` edges after the first edge with `rst_n`=1.
- Unmute: `RUN` is entered `UNMUTE_DLY` edges after `sht_dwn` falls. `mute` falls on the first `vld` edge at or after entry to `RUN`.
- Fault latency: `Flt_n` first sampled low at edge 0 → `fault_q` high after edge `FLT_FILT`+2.
- `sht_dwn` and `mute` rise after edge `FLT_FILT`+3.
- `Flt_n` low pulses shorter than `FLT_FILT` cycles never assert `fault_q`.
- `lockout` rises and falls on the same edge as the state change.
- `retry_cnt` updates on the fault-entry edge.

## Test plan
Bench parameters: `HOLD_CYC`=100, `UNMUTE_DLY`=20, `FLT_FILT`=4, `MAX_RETRY`=3, `STABLE_CYC`=1000, `vld` every 16 cycles.

- **Reset release, `Flt_n`=1:**
  - `sht_dwn`=1 for exactly 100 cycles, then 0.
  - `mute` falls at the first `vld` ≥120 cycles after release.
  - `retry_cnt`=0 throughout.
- **Glitch filter:**
  - 3-cycle `Flt_n` low pulse in `RUN`: no change on any output.
  - 4-cycle pulse: `sht_dwn`=`mute`=1 exactly 7 edges after the first low sample, `retry_cnt`=1.
  - `sht_dwn` falls 100 cycles after `fault_q` clears.
  - `mute` clears at the first `vld` ≥20 cycles after `sht_dwn` falls.
- **Lockout:**
  - Four qualified faults, each before `STABLE_CYC` elapses: `retry_cnt` reads 1, 2, 3, then `lockout`=1 with `retry_cnt`=3.
  - `sht_dwn`/`mute` stay 1 indefinitely.
  - `clr_lockout` pulse: `lockout`=0, `retry_cnt`=0, 100-cycle startup hold repeats.
- **Retry decay:** one fault, then 1000 continuous `RUN` cycles → `retry_cnt` returns to 0. A further 4 faults are then needed to reach lockout.
- **Fault held through `FAULT`:** `Flt_n` low for 500 cycles → `sht_dwn` stays high until 100 cycles after `fault_q` clears. `retry_cnt` increments only once.
- **Reset mid-fault:** assert `rst_n`=0 during `FAULT` with `retry_cnt`=2 → on the next edge `retry_cnt`=0, `sht_dwn`=1, `mute`=1, `lockout`=0. The full 100-cycle startup follows.
